// File: rtl/xgmii_frame_pkg.sv
// Shared types and constants for the XGMII frame generator.
// Character codes, FSM states, modes and CRC-32 constants.
package xgmii_frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOP,
    S_BODY,
    S_TAIL,
    S_IPG
  } state_t;

  typedef enum logic [1:0] {
    M_NORMAL,
    M_BAD_FCS,
    M_ERR_FCS,
    M_RSVD
  } mode_t;

  localparam logic [7:0] C_IDLE  = 8'h07;
  localparam logic [7:0] C_START = 8'hFB;
  localparam logic [7:0] C_TERM  = 8'hFD;
  localparam logic [7:0] C_ERR   = 8'hFE;
  localparam logic [7:0] C_PRE   = 8'h55;
  localparam logic [7:0] C_SFD   = 8'hD5;

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_lanes.sv
// Byte-masked 8-lane CRC-32 step, reflected, lane 0 first.
// Only lanes 0..valid_lanes-1 are folded into the register.
module crc32_lanes
  import xgmii_frame_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [63:0] data,
  input  logic [3:0]  valid_lanes,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_R = reflect32(CRC_POLY);

  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < valid_lanes) begin
        c = c ^ {24'h0, data[8*k +: 8]};
        for (int b = 0; b < 8; b++)
          c = c[0] ? ((c >> 1) ^ POLY_R) : (c >> 1);
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/xgmii_frame_gen.sv
// 64-bit XGMII frame source: SOP, header, padded payload,
// CRC-32 FCS, any-lane terminate and programmable IPG.
module xgmii_frame_gen
  import xgmii_frame_pkg::*;
#(
  parameter logic [47:0] DST_ADDR    = 48'h0180C2000001,
  parameter logic [47:0] SRC_ADDR    = 48'h5A5152535455,
  parameter logic [15:0] LEN_TYP     = 16'h8808,
  parameter int          MIN_PAYLOAD = 46,
  parameter int          MAX_PAYLOAD = 1500,
  parameter int          IPG_BYTES   = 12,
  parameter int          LEN_WIDTH   = 11
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [LEN_WIDTH-1:0] i_payload_len,
  input  logic [1:0]           i_mode,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [63:0]          o_tx_data,
  output logic [7:0]           o_tx_ctrl
);

  localparam int OW = 16;
  localparam logic [OW-1:0] MINP = OW'(MIN_PAYLOAD);
  localparam logic [OW-1:0] MAXP = OW'(MAX_PAYLOAD);
  localparam logic [15:0]   IPG_SAT = 16'(IPG_BYTES);

  state_t        state_q, state_d;
  mode_t         mode_q, mode_d;
  logic [OW-1:0] ncap_q, ncap_d;
  logic [OW-1:0] flen_q, flen_d;
  logic [OW-1:0] wcnt_q, wcnt_d;
  logic [OW-1:0] n_req, n_cap;
  logic [15:0]   ipg_q, ipg_d;
  logic [31:0]   crc_q, crc_d;
  logic [31:0]   crc_out, crc_nxt, fcs;
  logic [63:0]   pay_w;
  logic [3:0]    nvalid, crc_lanes;
  logic          ipg_ok;

  function automatic logic [15:0] ipg_add(
    input logic [15:0] a,
    input logic [15:0] b
  );
    return (a + b >= IPG_SAT) ? IPG_SAT : a + b;
  endfunction

  // The idle word currently on the wire counts toward the gap.
  assign ipg_ok = (ipg_q + 16'd8 >= IPG_SAT);
  assign o_busy = (state_q != S_IDLE) || !ipg_ok;

  always_comb begin
    int o;
    int dlen;
    pay_w  = '0;
    nvalid = '0;
    o      = 0;
    dlen   = int'(flen_q) - 4 - int'(wcnt_q) * 8;
    for (int k = 0; k < 8; k++) begin
      o = int'(wcnt_q) * 8 + k;
      if (o < 6)
        pay_w[8*k +: 8] = DST_ADDR[8*(5-o) +: 8];
      else if (o < 12)
        pay_w[8*k +: 8] = SRC_ADDR[8*(11-o) +: 8];
      else if (o < 14)
        pay_w[8*k +: 8] = LEN_TYP[8*(13-o) +: 8];
      else if (o - 14 < int'(ncap_q))
        pay_w[8*k +: 8] = 8'(o - 14);
    end
    if (dlen >= 8)
      nvalid = 4'd8;
    else if (dlen > 0)
      nvalid = 4'(dlen);
  end

  assign crc_lanes = (nvalid == 4'd0) ? 4'd1 : nvalid;

  crc32_lanes u_crc (
    .crc_in     (crc_q),
    .data       (pay_w),
    .valid_lanes(crc_lanes),
    .crc_out    (crc_out)
  );

  assign crc_nxt = (nvalid == 4'd0) ? crc_q : crc_out;

  always_comb begin
    int o;
    int fb;
    o_tx_data = {8{C_IDLE}};
    o_tx_ctrl = 8'hFF;
    o_done    = 1'b0;
    o         = 0;
    fb        = 0;
    fcs = (mode_q == M_BAD_FCS) ? crc_nxt : ~crc_nxt;
    unique case (1'b1)
      (state_q == S_SOP): begin
        o_tx_data = {C_SFD, {6{C_PRE}}, C_START};
        o_tx_ctrl = 8'h01;
      end
      (state_q == S_BODY), (state_q == S_TAIL): begin
        o_done = (state_q == S_TAIL);
        for (int k = 0; k < 8; k++) begin
          o  = int'(wcnt_q) * 8 + k;
          fb = o - (int'(flen_q) - 4);
          if (fb < 0) begin
            o_tx_data[8*k +: 8] = pay_w[8*k +: 8];
            o_tx_ctrl[k] = 1'b0;
          end else if (fb < 4) begin
            if (mode_q == M_ERR_FCS) begin
              o_tx_data[8*k +: 8] = C_ERR;
            end else begin
              o_tx_data[8*k +: 8] = fcs[8*fb +: 8];
              o_tx_ctrl[k] = 1'b0;
            end
          end else if (fb == 4) begin
            o_tx_data[8*k +: 8] = C_TERM;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    ncap_d  = ncap_q;
    flen_d  = flen_q;
    wcnt_d  = wcnt_q;
    crc_d   = crc_q;
    ipg_d   = ipg_q;
    n_req   = OW'(i_payload_len);
    n_cap   = (n_req > MAXP) ? MAXP : n_req;
    unique case (state_q)
      S_IDLE: begin
        ipg_d = ipg_add(ipg_q, 16'd8);
        if (i_start && ipg_ok) begin
          state_d = S_SOP;
          mode_d  = mode_t'(i_mode);
          ncap_d  = n_cap;
          flen_d  = OW'(18) + ((n_cap < MINP) ? MINP : n_cap);
        end
      end
      S_SOP: begin
        state_d = S_BODY;
        wcnt_d  = '0;
        crc_d   = CRC_INIT;
      end
      S_BODY: begin
        crc_d  = crc_nxt;
        wcnt_d = wcnt_q + OW'(1);
        if (wcnt_d == (flen_q >> 3))
          state_d = S_TAIL;
      end
      S_TAIL: begin
        ipg_d   = ipg_add(16'd0, 16'(3'd7 - flen_q[2:0]));
        state_d = (ipg_d + 16'd8 >= IPG_SAT) ? S_IDLE : S_IPG;
      end
      S_IPG: begin
        ipg_d   = ipg_add(ipg_q, 16'd8);
        state_d = (ipg_d + 16'd8 >= IPG_SAT) ? S_IDLE : S_IPG;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      mode_q  <= M_NORMAL;
      ncap_q  <= '0;
      flen_q  <= '0;
      wcnt_q  <= '0;
      crc_q   <= CRC_INIT;
      ipg_q   <= IPG_SAT;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      ncap_q  <= ncap_d;
      flen_q  <= flen_d;
      wcnt_q  <= wcnt_d;
      crc_q   <= crc_d;
      ipg_q   <= ipg_d;
    end
  end

endmodule

// File: tb/tb_xgmii_frame_gen.sv
// Randomised bench for xgmii_frame_gen with a byte-level
// frame model (header, payload, pad, FCS, T, IPG).
module tb_xgmii_frame_gen;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [10:0] i_payload_len;
  logic [1:0]  i_mode;
  logic        o_busy;
  logic        o_done;
  logic [63:0] o_tx_data;
  logic [7:0]  o_tx_ctrl;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_b[$];
  bit         exp_c[$];
  int         exp_l = 0;

  always #5 clk = ~clk;

  xgmii_frame_gen dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_payload_len(i_payload_len),
    .i_mode       (i_mode),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_tx_data    (o_tx_data),
    .o_tx_ctrl    (o_tx_ctrl)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Idle words after the T word for a back-to-back request.
  function automatic int idles_after(input int l);
    int t;
    t = 7 - (l % 8);
    return (12 - t + 7) / 8;
  endfunction

  task automatic build(input int n, input int mode);
    logic [47:0] da;
    logic [47:0] sa;
    logic [15:0] lt;
    logic [31:0] crc;
    logic [31:0] fcs;
    int p;
    da = 48'h0180C2000001;
    sa = 48'h5A5152535455;
    lt = 16'h8808;
    p = (n < 46) ? 46 : ((n > 1500) ? 1500 : n);
    exp_l = 18 + p;
    exp_b.delete();
    exp_c.delete();
    for (int i = 0; i < 6; i++) exp_b.push_back(da[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) exp_b.push_back(sa[47-8*i -: 8]);
    exp_b.push_back(lt[15:8]);
    exp_b.push_back(lt[7:0]);
    for (int i = 0; i < p; i++)
      exp_b.push_back((i < n) ? 8'(i) : 8'h00);
    crc = 32'hFFFFFFFF;
    foreach (exp_b[i]) crc = crc_upd(crc, exp_b[i]);
    for (int i = 0; i < exp_b.size(); i++) exp_c.push_back(1'b0);
    fcs = (mode == 1) ? crc : ~crc;
    for (int j = 0; j < 4; j++) begin
      exp_b.push_back((mode == 2) ? 8'hFE : fcs[8*j +: 8]);
      exp_c.push_back(mode == 2);
    end
    exp_b.push_back(8'hFD);
    exp_c.push_back(1'b1);
    while (exp_b.size() % 8 != 0) begin
      exp_b.push_back(8'h07);
      exp_c.push_back(1'b1);
    end
  endtask

  task automatic go(input int n, input int mode);
    i_start       = 1'b1;
    i_payload_len = 11'(n);
    i_mode        = 2'(mode);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (o_busy && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("idle_reached", o_busy, 0);
  endtask

  task automatic expect_frame(
    input int n,
    input int mode,
    input bit noisy,
    input int exp_idles
  );
    int          idles;
    bit          seen;
    int          done_cnt;
    int          done_idx;
    logic [63:0] ew;
    logic [7:0]  ecw;
    logic [7:0]  obs[$];
    logic [31:0] crc;
    idles = 0;
    seen = 1'b0;
    done_cnt = 0;
    done_idx = -1;
    ew = '0;
    ecw = '0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (o_tx_ctrl[0] && o_tx_data[7:0] == 8'hFB) begin
        seen = 1'b1;
      end else begin
        idles++;
        chk("gap_data", o_tx_data, {8{8'h07}});
        chk("gap_ctrl", o_tx_ctrl, 8'hFF);
      end
    end
    chk("sop_seen", seen, 1);
    if (!seen) return;
    chk("sop_gap", idles, exp_idles);
    chk("sop_data", o_tx_data, 64'hD5555555555555FB);
    chk("sop_ctrl", o_tx_ctrl, 8'h01);
    chk("sop_busy", o_busy, 1);
    build(n, mode);
    for (int w = 0; w < exp_b.size() / 8; w++) begin
      i_start = noisy ? 1'($urandom) : 1'b0;
      if (noisy) begin
        i_payload_len = 11'($urandom);
        i_mode        = 2'($urandom);
      end
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        ew[8*k +: 8] = exp_b[8*w+k];
        ecw[k]       = exp_c[8*w+k];
        obs.push_back(o_tx_data[8*k +: 8]);
      end
      chk($sformatf("w%0d_data", w), o_tx_data, ew);
      chk($sformatf("w%0d_ctrl", w), o_tx_ctrl, ecw);
      chk($sformatf("w%0d_busy", w), o_busy, 1);
      if (o_done) begin
        done_cnt++;
        done_idx = w;
      end
    end
    i_start = 1'b0;
    chk("done_cnt", done_cnt, 1);
    chk("t_word", done_idx, exp_l / 8);
    if (mode != 2) begin
      crc = 32'hFFFFFFFF;
      for (int i = 0; i < exp_l; i++) crc = crc_upd(crc, obs[i]);
      chk("residue_hit", rev32(crc) == 32'hC704DD7B, mode != 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int m;
    int bad;
    i_rst         = 1'b1;
    i_start       = 1'b0;
    i_payload_len = '0;
    i_mode        = '0;
    repeat (3) @(negedge clk);
    chk("rst_data", o_tx_data, {8{8'h07}});
    chk("rst_ctrl", o_tx_ctrl, 8'hFF);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    i_rst = 1'b0;
    @(negedge clk);

    go(46, 0);
    expect_frame(46, 0, 0, 0);
    go(50, 0);
    expect_frame(50, 0, 0, idles_after(exp_l));
    go(10, 0);
    expect_frame(10, 0, 0, idles_after(exp_l));
    go(2000, 0);
    expect_frame(2000, 0, 0, idles_after(exp_l));
    go(0, 0);
    expect_frame(0, 0, 0, idles_after(exp_l));
    for (int md = 0; md < 4; md++) begin
      go(61, md);
      expect_frame(61, md, 0, idles_after(exp_l));
    end

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(0, 2047);
      m = $urandom_range(0, 3);
      if (r % 2 == 1) begin
        wait_idle();
        go(n, m);
        expect_frame(n, m, 1, 0);
      end else begin
        go(n, m);
        expect_frame(n, m, 1, idles_after(exp_l));
      end
    end

    // Reset while the third body word is on the wire.
    wait_idle();
    go(100, 0);
    @(negedge clk);
    chk("rst_sop_ctrl", o_tx_ctrl, 8'h01);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_data", o_tx_data, {8{8'h07}});
    chk("mid_rst_ctrl", o_tx_ctrl, 8'hFF);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_done", o_done, 0);
    i_rst = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_tx_ctrl != 8'hFF || o_tx_data != {8{8'h07}} || o_done)
        bad++;
    end
    chk("post_rst_quiet", bad, 0);
    go(70, 2);
    expect_frame(70, 2, 0, 0);
    go(57, 3);
    expect_frame(57, 3, 0, idles_after(exp_l));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
